arc4_sched: RTL

//  Parametrised ARC4 state-array scheduler: fills S[i]=i and, in KSA mode, runs the key-scheduling swap pass.

---
 rtl/arc4_pkg.sv | 19 +
 rtl/arc4_key_sel.sv | 21 ++
 rtl/arc4_sched.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/arc4_pkg.sv
// Shared ARC4 definitions: scheduler state encoding and the S-array depth helper.
package arc4_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        RD_I,
        WT_I,
        RD_J,
        WT_J,
        WR_J,
        WR_I
    } sched_state_t;

    function automatic int unsigned arc4_depth(input int unsigned w);
        return 32'd1 << w;
    endfunction

endpackage

// File: rtl/arc4_key_sel.sv
// Combinational key element selector; element 0 sits in the most significant DATA_W bits.
module arc4_key_sel #(
    parameter int DATA_W  = 8,
    parameter int KEY_LEN = 3,
    parameter int KIDX_W  = 2
) (
    input  logic [KEY_LEN*DATA_W-1:0] key_i,
    input  logic [KIDX_W-1:0]         idx_i,
    output logic [DATA_W-1:0]         elem_o
);

    always_comb begin
        elem_o = '0;
        for (int n = 0; n < KEY_LEN; n++) begin
            if (idx_i == KIDX_W'(n)) begin
                elem_o = key_i[(KEY_LEN-1-n)*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/arc4_sched.sv
// ARC4 S-array scheduler: identity fill, optionally followed by the KSA swap pass.
// The KSA pass is compiled in only when ARC4_SCHED_KSA_EN is defined.
module arc4_sched
    import arc4_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int KEY_LEN = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    output logic                      rdy,
    input  logic                      mode,
    input  logic [KEY_LEN*DATA_W-1:0] key,
    output logic [DATA_W-1:0]         addr,
    input  logic [DATA_W-1:0]         rddata,
    output logic [DATA_W-1:0]         wrdata,
    output logic                      wren
);

    localparam logic [DATA_W-1:0] I_MAX = DATA_W'(arc4_depth(DATA_W) - 1);

    sched_state_t      state_q;
    logic [DATA_W-1:0] i_q;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] wrdata_q;
    logic              wren_q;
    logic              rdy_q;

`ifdef ARC4_SCHED_KSA_EN
    localparam int KIDX_W = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
    localparam logic [KIDX_W-1:0] KIDX_LAST = KIDX_W'(KEY_LEN - 1);

    logic [KIDX_W-1:0]         kidx_q;
    logic [DATA_W-1:0]         j_q;
    logic [DATA_W-1:0]         j_d;
    logic [DATA_W-1:0]         si_q;
    logic [DATA_W-1:0]         sj_q;
    logic [DATA_W-1:0]         kelem;
    logic [KEY_LEN*DATA_W-1:0] key_q;
    logic                      mode_q;

    arc4_key_sel #(
        .DATA_W  (DATA_W),
        .KEY_LEN (KEY_LEN),
        .KIDX_W  (KIDX_W)
    ) u_key_sel (
        .key_i  (key_q),
        .idx_i  (kidx_q),
        .elem_o (kelem)
    );

    // rddata holds S[i] during WT_I, so the new j is formed straight from it.
    assign j_d = j_q + rddata + kelem;
`else
    logic unused_ok;
    assign unused_ok = ^{mode, key, rddata};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rdy_q    <= 1'b1;
            wren_q   <= 1'b0;
            addr_q   <= '0;
            wrdata_q <= '0;
            i_q      <= '0;
`ifdef ARC4_SCHED_KSA_EN
            j_q      <= '0;
            kidx_q   <= '0;
            si_q     <= '0;
            sj_q     <= '0;
            key_q    <= '0;
            mode_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (en) begin
                        state_q  <= FILL;
                        rdy_q    <= 1'b0;
                        i_q      <= '0;
                        addr_q   <= '0;
                        wrdata_q <= '0;
                        wren_q   <= 1'b1;
`ifdef ARC4_SCHED_KSA_EN
                        key_q    <= key;
                        mode_q   <= mode;
`endif
                    end
                end
                FILL: begin
                    if (i_q == I_MAX) begin
                        wren_q <= 1'b0;
                        i_q    <= '0;
`ifdef ARC4_SCHED_KSA_EN
                        if (mode_q) begin
                            state_q <= RD_I;
                            addr_q  <= '0;
                            j_q     <= '0;
                            kidx_q  <= '0;
                        end else begin
                            state_q <= IDLE;
                            rdy_q   <= 1'b1;
                        end
`else
                        state_q <= IDLE;
                        rdy_q   <= 1'b1;
`endif
                    end else begin
                        i_q      <= i_q + 1'b1;
                        addr_q   <= i_q + 1'b1;
                        wrdata_q <= i_q + 1'b1;
                    end
                end
`ifdef ARC4_SCHED_KSA_EN
                RD_I: state_q <= WT_I;
                WT_I: begin
                    si_q    <= rddata;
                    j_q     <= j_d;
                    addr_q  <= j_d;
                    state_q <= RD_J;
                end
                RD_J: state_q <= WT_J;
                WT_J: begin
                    sj_q     <= rddata;
                    addr_q   <= j_q;
                    wrdata_q <= si_q;
                    wren_q   <= 1'b1;
                    state_q  <= WR_J;
                end
                // i==j needs no special case: both writes carry the same value.
                WR_J: begin
                    addr_q   <= i_q;
                    wrdata_q <= sj_q;
                    state_q  <= WR_I;
                end
                WR_I: begin
                    wren_q <= 1'b0;
                    if (i_q == I_MAX) begin
                        state_q <= IDLE;
                        rdy_q   <= 1'b1;
                    end else begin
                        i_q     <= i_q + 1'b1;
                        addr_q  <= i_q + 1'b1;
                        kidx_q  <= (kidx_q == KIDX_LAST) ? '0 : kidx_q + 1'b1;
                        state_q <= RD_I;
                    end
                end
`endif
                default: begin
                    state_q <= IDLE;
                    rdy_q   <= 1'b1;
                    wren_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rdy    = rdy_q;
    assign addr   = addr_q;
    assign wrdata = wrdata_q;
    assign wren   = wren_q;

endmodule
